// File: rtl/rr_bus_mux.sv
// rr_bus_mux: forwards the arbiter-granted port's beat through one registered valid/ready stage,
// locking the source for multi-beat packets. Optional grant checker: define RR_BUS_MUX_CHECK_EN.
//
// state | meaning
// IDLE  | arbitrating; each granted beat is accepted, and a non-last beat moves to LOCK
// LOCK  | mid-packet; only lock_sel is served until its last beat
module rr_bus_mux #(
  parameter int PORTS = 4,
  parameter int DW    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PORTS-1:0]    req_vld,
  input  logic [PORTS*DW-1:0] req_data,
  input  logic [PORTS-1:0]    req_last,
  output logic [PORTS-1:0]    req_rdy,
  output logic [PORTS-1:0]    arb_req,
  output logic                arb_pause,
  input  logic [PORTS-1:0]    arb_gnt,
  output logic                out_vld,
  output logic [DW-1:0]       out_data,
  output logic                out_last,
  output logic [PORTS-1:0]    out_src,
  input  logic                out_rdy,
  output logic                err_gnt
);

  typedef enum logic [0:0] {IDLE, LOCK} state_t;

  state_t           state;
  logic [PORTS-1:0] lock_sel;
  logic [PORTS-1:0] sel;
  logic [DW-1:0]    sel_data;
  logic             sel_last;
  logic             can_load;
  logic             load;

  assign can_load = !out_vld || out_rdy;

  // Requests are withheld while stalled so the arbiter pointer does not move.
  always_comb begin
    sel       = '0;
    arb_req   = '0;
    arb_pause = 1'b0;
    if (!rst) begin
      if (state == IDLE) begin
        arb_pause = !can_load;
        if (can_load) begin
          arb_req = req_vld;
          sel     = arb_gnt;
        end
      end else begin
        arb_pause = 1'b1;
        if (can_load) sel = req_vld & lock_sel;
      end
    end
  end

  assign req_rdy = sel;
  assign load    = |sel;

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      sel_data = sel_data | ({DW{sel[i]}} & req_data[i*DW +: DW]);
      sel_last = sel_last | (sel[i] & req_last[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lock_sel <= '0;
      out_vld  <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      out_src  <= '0;
    end else begin
      if (load) begin
        out_vld  <= 1'b1;
        out_data <= sel_data;
        out_last <= sel_last;
        out_src  <= sel;
        if (state == IDLE) begin
          lock_sel <= sel;
          if (!sel_last) state <= LOCK;
        end else if (sel_last) begin
          state <= IDLE;
        end
      end else if (out_vld && out_rdy) begin
        out_vld <= 1'b0;
      end
    end
  end

`ifdef RR_BUS_MUX_CHECK_EN
  logic gnt_bad;

  always_comb begin
    gnt_bad = 1'b0;
    if (state == IDLE && can_load) begin
      if ((arb_gnt & (arb_gnt - PORTS'(1))) != '0) gnt_bad = 1'b1;
      if ((arb_gnt & ~req_vld) != '0)               gnt_bad = 1'b1;
    end
`ifndef SYNTHESIS
    if (out_vld && $isunknown(out_rdy)) gnt_bad = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst)          err_gnt <= 1'b0;
    else if (gnt_bad) err_gnt <= 1'b1;
  end
`else
  assign err_gnt = 1'b0;
`endif

endmodule

// File: tb/tb_rr_bus_mux.sv
// Scoreboard bench for rr_bus_mux: queued sources, a round-robin arbiter model,
// and a monitor that checks every accepted output beat against directed expectations.
module tb_rr_bus_mux;
  localparam int P = 4;
  localparam int W = 32;
`ifdef RR_BUS_MUX_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [P-1:0] req_vld = '0, req_last = '0;
  logic [P*W-1:0] req_data = '0;
  logic [P-1:0] req_rdy, arb_req, arb_gnt, out_src;
  logic         arb_pause, out_vld, out_last, err_gnt;
  logic         out_rdy = 1'b1;
  logic [W-1:0] out_data;

  always #5 clk = ~clk;

  rr_bus_mux #(.PORTS(P), .DW(W)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_data(req_data), .req_last(req_last), .req_rdy(req_rdy),
    .arb_req(arb_req), .arb_pause(arb_pause), .arb_gnt(arb_gnt),
    .out_vld(out_vld), .out_data(out_data), .out_last(out_last), .out_src(out_src),
    .out_rdy(out_rdy), .err_gnt(err_gnt)
  );

  typedef struct packed {
    logic [P-1:0] src;
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  beat_t        expq[$];
  beat_t        e;
  logic [W:0]   srcq[P][$];
  logic [P-1:0] gap = '0, pop_mask = '0, force_val = '0;
  logic         force_en = 1'b0, adv = 1'b0;
  int           ptr = 0, adv_idx = 0;
  int           tests = 0, fails = 0;

  // Round-robin arbiter model, with an override for protocol-error injection.
  always_comb begin
    logic found;
    int   idx;
    found   = 1'b0;
    idx     = 0;
    arb_gnt = '0;
    if (force_en) arb_gnt = force_val;
    else begin
      for (int k = 0; k < P; k++) begin
        idx = (ptr + k) % P;
        if (!found && arb_req[idx]) begin
          arb_gnt[idx] = 1'b1;
          found        = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    pop_mask = rst ? '0 : req_rdy;
    adv      = !rst && !force_en && !arb_pause && (arb_gnt != '0);
    for (int k = 0; k < P; k++) if (arb_gnt[k]) adv_idx = k;
  end

  // Monitor: every accepted output beat is compared with the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_vld === 1'b1 && out_rdy === 1'b1) begin
      tests++;
      if (expq.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got src=%b data=%h last=%b, required no beat",
                 out_src, out_data, out_last);
      end else begin
        e = expq.pop_front();
        if ({out_src, out_data, out_last} !== e) begin
          fails++;
          $display("FAIL sb_beat: got src=%b data=%h last=%b, required src=%b data=%h last=%b",
                   out_src, out_data, out_last, e.src, e.data, e.last);
        end
      end
    end
  end

  function automatic logic [W-1:0] dat(int p, int k);
    return 32'hD000_0000 + W'(p * 256) + W'(k);
  endfunction

  function automatic void drive();
    for (int i = 0; i < P; i++) begin
      req_vld[i]          = (srcq[i].size() != 0) && !gap[i];
      req_data[i*W +: W]  = (srcq[i].size() != 0) ? srcq[i][0][W-1:0] : '0;
      req_last[i]         = (srcq[i].size() != 0) ? srcq[i][0][W] : 1'b0;
    end
  endfunction

  task automatic push_pkt(input int p, input int n, input int k0);
    for (int k = 0; k < n; k++) srcq[p].push_back({(k == n - 1), dat(p, k0 + k)});
  endtask

  task automatic exp_beat(input logic [P-1:0] s, input logic [W-1:0] d, input logic l);
    expq.push_back('{src: s, data: d, last: l});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < P; i++)
      if (pop_mask[i] && srcq[i].size() != 0) void'(srcq[i].pop_front());
    if (adv) ptr = (adv_idx + 1) % P;
    pop_mask = '0;
    adv      = 1'b0;
    drive();
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (expq.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    tick();
    chk("sb_drain_timeout", 64'(expq.size()), 64'd0);
  endtask

  logic [P-1:0] seq1 [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [P-1:0] seq2 [4] = '{4'b0010, 4'b0010, 4'b0010, 4'b0100};
  logic         lst2 [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    drive();
    repeat (3) tick();
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_req_rdy", req_rdy, 0);
    chk("rst_arb_req", arb_req, 0);
    chk("rst_arb_pause", arb_pause, 0);
    chk("rst_err_gnt", err_gnt, 0);
    rst = 1'b0;
    tick();
    chk("idle_arb_pause", arb_pause, 0);

    // Four single-beat sources, full throughput.
    for (int p = 0; p < P; p++) push_pkt(p, 1, 0);
    push_pkt(0, 1, 1);
    exp_beat(4'b0001, 32'hD000_0000, 1'b1);
    exp_beat(4'b0010, 32'hD000_0100, 1'b1);
    exp_beat(4'b0100, 32'hD000_0200, 1'b1);
    exp_beat(4'b1000, 32'hD000_0300, 1'b1);
    exp_beat(4'b0001, 32'hD000_0001, 1'b1);
    drive();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_vld", out_vld, 1);
      chk("rr_src", out_src, seq1[k]);
    end
    wait_empty(10);

    // 3-beat packet from port 1 with port 2 waiting.
    push_pkt(1, 3, 0);
    push_pkt(2, 1, 0);
    exp_beat(4'b0010, 32'hD000_0100, 1'b0);
    exp_beat(4'b0010, 32'hD000_0101, 1'b0);
    exp_beat(4'b0010, 32'hD000_0102, 1'b1);
    exp_beat(4'b0100, 32'hD000_0200, 1'b1);
    drive();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("lock_src", out_src, seq2[k]);
      chk("lock_last", out_last, lst2[k]);
      if (k == 0) begin
        chk("lock_arb_req", arb_req, 0);
        chk("lock_arb_pause", arb_pause, 1);
        chk("lock_req_rdy", req_rdy, 4'b0010);
      end
    end
    wait_empty(10);

    // Locked port 0 with a 2-cycle valid gap while others wait.
    push_pkt(0, 3, 0);
    exp_beat(4'b0001, 32'hD000_0000, 1'b0);
    exp_beat(4'b0001, 32'hD000_0001, 1'b0);
    exp_beat(4'b0001, 32'hD000_0002, 1'b1);
    exp_beat(4'b0010, 32'hD000_0100, 1'b1);
    exp_beat(4'b0100, 32'hD000_0200, 1'b1);
    exp_beat(4'b1000, 32'hD000_0300, 1'b1);
    drive();
    tick();
    chk("gap_first_src", out_src, 4'b0001);
    gap[0] = 1'b1;
    push_pkt(1, 1, 0);
    push_pkt(2, 1, 0);
    push_pkt(3, 1, 0);
    drive();
    #1;
    chk("gap_req_rdy", req_rdy, 0);
    chk("gap_arb_req", arb_req, 0);
    repeat (2) begin
      tick();
      chk("gap_out_vld", out_vld, 0);
      chk("gap_req_rdy", req_rdy, 0);
      chk("gap_arb_req", arb_req, 0);
    end
    gap[0] = 1'b0;
    drive();
    tick();
    chk("gap_resume_src", out_src, 4'b0001);
    tick();
    chk("gap_resume_last", out_last, 1);
    tick();
    chk("gap_next_src", out_src, 4'b0010);
    wait_empty(10);

    // Downstream stall with three queued singles.
    out_rdy = 1'b0;
    push_pkt(1, 1, 0);
    push_pkt(2, 1, 0);
    push_pkt(3, 1, 0);
    exp_beat(4'b0010, 32'hD000_0100, 1'b1);
    exp_beat(4'b0100, 32'hD000_0200, 1'b1);
    exp_beat(4'b1000, 32'hD000_0300, 1'b1);
    drive();
    tick();
    repeat (5) begin
      chk("stall_vld", out_vld, 1);
      chk("stall_src", out_src, 4'b0010);
      chk("stall_data", out_data, 32'hD000_0100);
      chk("stall_req_rdy", req_rdy, 0);
      chk("stall_arb_req", arb_req, 0);
      tick();
    end
    out_rdy = 1'b1;
    #1;
    chk("release_req_rdy", req_rdy, 4'b0100);
    tick();
    chk("release_src1", out_src, 4'b0100);
    tick();
    chk("release_src2", out_src, 4'b1000);
    wait_empty(10);

    // Reset in the middle of a 4-beat packet from port 2.
    push_pkt(2, 4, 0);
    exp_beat(4'b0100, 32'hD000_0200, 1'b0);
    drive();
    tick();
    chk("mid_first_src", out_src, 4'b0100);
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_req_rdy", req_rdy, 0);
    tick();
    rst = 1'b0;
    srcq[2].delete();
    push_pkt(3, 1, 0);
    exp_beat(4'b1000, 32'hD000_0300, 1'b1);
    drive();
    #1;
    chk("post_rst_vld", out_vld, 0);
    chk("post_rst_pause", arb_pause, 0);
    chk("post_rst_req_rdy", req_rdy, 4'b1000);
    tick();
    chk("post_rst_src", out_src, 4'b1000);
    wait_empty(10);

    // Non-one-hot grant injected in IDLE.
    chk("pre_err_gnt", err_gnt, 0);
    push_pkt(0, 1, 5);
    push_pkt(1, 1, 5);
    exp_beat(4'b0011, 32'hD000_0105, 1'b1);
    force_en  = 1'b1;
    force_val = 4'b0011;
    drive();
    tick();
    force_en = 1'b0;
    #1;
    chk("err_gnt_set", err_gnt, EXP_ERR);
    repeat (3) tick();
    chk("err_gnt_sticky", err_gnt, EXP_ERR);
    wait_empty(10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("err_gnt_cleared", err_gnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
